stopwatch_ctrl: RTL and testbench

Control block for the stopwatch BCD counter (the six-digit 10 ms..10 min timer). It debounces the three front-panel buttons, runs a run/pause/lap/idle state machine, and generates the counter's sequencing signals: a 10 ms tick, an enable, a one-cycle clear, a latched count mode, and a lap-freeze flag for the display path. It sits between the raw board buttons and the counter/display.

---
 rtl/stopwatch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch button debounce, run/pause/lap FSM and counter sequencing
module stopwatch_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_startstop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic       mode_sel,
  output logic       count_enable,
  output logic       count_tick,
  output logic       count_clear,
  output logic       count_mode,
  output logic       lap_hold,
  output logic [1:0] state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  // Button bit order: 0 = startstop, 1 = clear, 2 = lap.
  logic [2:0]         btn_raw;
  logic [2:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]         level_q, level_d, press_q, press_d;
  logic [2:0][DW-1:0] db_cnt_q, db_cnt_d;

  state_t        state_q, state_d;
  logic          clear_go;
  logic          count_enable_q, count_enable_d;
  logic          lap_hold_q, lap_hold_d;
  logic          count_clear_q, count_clear_d;
  logic          count_mode_q, count_mode_d;
  logic          count_tick_q, count_tick_d;
  logic [PW-1:0] presc_q, presc_d;

  assign btn_raw = {btn_lap, btn_clear, btn_startstop};

  // Two-flop synchronizer feeding a per-button stability counter; a press pulse fires on a 0->1 flip.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    level_d  = level_q;
    press_d  = '0;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Button path registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      press_q  <= '0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; startstop wins over clear, clear over lap, and losers are simply dropped.
  always_comb begin
    state_d  = state_q;
    clear_go = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_q[0])      state_d = S_RUN;
        else if (press_q[1]) clear_go = 1'b1;
      end
      S_RUN: begin
        if (press_q[0])      state_d = S_PAUSE;
        else if (press_q[2]) state_d = S_LAP;
      end
      S_LAP: begin
        if (press_q[0])      state_d = S_PAUSE;
        else if (press_q[2]) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (press_q[0]) begin
          state_d = S_RUN;
        end else if (press_q[1]) begin
          state_d  = S_IDLE;
          clear_go = 1'b1;
        end
      end
    endcase
  end

  // Outputs decoded from the next state so they register on the same edge as the state change.
  always_comb begin
    count_enable_d = (state_d == S_RUN) || (state_d == S_LAP);
    lap_hold_d     = (state_d == S_LAP);
    count_clear_d  = clear_go;
    count_mode_d   = (state_q == S_IDLE) ? mode_sel : count_mode_q;
  end

  // Prescaler advances only on enabled cycles, so a pause keeps the partial interval.
  always_comb begin
    presc_d      = presc_q;
    count_tick_d = 1'b0;
    if (clear_go) begin
      presc_d = '0;
    end else if (count_enable_q) begin
      if (presc_q == PRE_LAST) begin
        presc_d      = '0;
        count_tick_d = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Output and prescaler registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_enable_q <= 1'b0;
      lap_hold_q     <= 1'b0;
      count_clear_q  <= 1'b0;
      count_mode_q   <= 1'b0;
      count_tick_q   <= 1'b0;
      presc_q        <= '0;
    end else begin
      count_enable_q <= count_enable_d;
      lap_hold_q     <= lap_hold_d;
      count_clear_q  <= count_clear_d;
      count_mode_q   <= count_mode_d;
      count_tick_q   <= count_tick_d;
      presc_q        <= presc_d;
    end
  end

  assign state        = state_q;
  assign count_enable = count_enable_q;
  assign count_tick   = count_tick_q;
  assign count_clear  = count_clear_q;
  assign count_mode   = count_mode_q;
  assign lap_hold     = lap_hold_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_startstop = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic       mode_sel = 1'b0;
  logic       count_enable, count_tick, count_clear, count_mode, lap_hold;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [2:0] SS  = 3'b100;
  localparam logic [2:0] CLR = 3'b010;
  localparam logic [2:0] LAP = 3'b001;

  typedef struct {
    logic [2:0] btn;
    logic       msel;
    logic [1:0] st;
    logic       en;
    logic       lh;
    logic       clr;
    logic       md;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ(1000),
    .TICK_HZ(100),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_startstop(btn_startstop),
    .btn_lap(btn_lap),
    .btn_clear(btn_clear),
    .mode_sel(mode_sel),
    .count_enable(count_enable),
    .count_tick(count_tick),
    .count_clear(count_clear),
    .count_mode(count_mode),
    .lap_hold(lap_hold),
    .state(state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [2:0] b);
    {btn_startstop, btn_clear, btn_lap} = b;
  endtask

  // Hold 6 cycles, release, and stop just after the 7th edge where the state update lands.
  task automatic press(input logic [2:0] b);
    set_btn(b);
    step(6);
    set_btn(3'b000);
    step(1);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!count_tick && n < 40);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ev;

    tbl[0]  = '{LAP,      1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{LAP,      1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{CLR,      1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{LAP,      1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{CLR,      1'b0, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{SS,       1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{LAP,      1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{CLR,      1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{LAP,      1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{SS,       1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{SS,       1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{CLR,      1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{CLR,      1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{SS,       1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{SS,       1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{SS | CLR, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset values
    step(3);
    chk("rst_state", state, 2'b00);
    chk("rst_enable", count_enable, 1'b0);
    chk("rst_tick", count_tick, 1'b0);
    chk("rst_clear", count_clear, 1'b0);
    chk("rst_mode", count_mode, 1'b0);
    chk("rst_lap_hold", lap_hold, 1'b0);
    reset = 1'b1;
    step(2);

    // Start latency: state changes exactly 7 edges after the raw rise, ticks every 10 cycles
    btn_startstop = 1'b1;
    step(6);
    chk("start_edge6_state", state, 2'b00);
    step(1);
    chk("start_edge7_state", state, 2'b01);
    chk("start_enable", count_enable, 1'b1);
    wait_tick(n);
    chk("first_tick_delay", n, 10);
    wait_tick(n);
    chk("tick_period", n, 10);
    step(1);
    chk("tick_one_cycle", count_tick, 1'b0);
    btn_startstop = 1'b0;
    step(12);
    chk("hold_single_transition", state, 2'b01);

    // Bounce: two short glitches produce no press
    set_btn(SS); step(2); set_btn(3'b000); step(2);
    set_btn(SS); step(2); set_btn(3'b000);
    step(12);
    chk("glitch_no_change", state, 2'b01);

    // Pause 7 enabled cycles after a tick, then resume: tick after the remaining 3
    wait_tick(n);
    chk("pre_pause_tick_seen", count_tick, 1'b1);
    set_btn(SS);
    step(6);
    set_btn(3'b000);
    chk("pause_edge6_state", state, 2'b01);
    step(1);
    chk("pause_state", state, 2'b10);
    chk("pause_enable", count_enable, 1'b0);
    ev = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (count_tick) ev++;
    end
    chk("pause_no_tick", ev, 0);
    press(SS);
    chk("resume_state", state, 2'b01);
    wait_tick(n);
    chk("resume_remaining_interval", n, 3);
    step(8);

    // Table of single presses starting from RUN
    for (int i = 0; i < 16; i++) begin
      mode_sel = tbl[i].msel;
      press(tbl[i].btn);
      chk($sformatf("v%0d_state", i), state, tbl[i].st);
      chk($sformatf("v%0d_enable", i), count_enable, tbl[i].en);
      chk($sformatf("v%0d_lap_hold", i), lap_hold, tbl[i].lh);
      chk($sformatf("v%0d_clear", i), count_clear, tbl[i].clr);
      chk($sformatf("v%0d_mode", i), count_mode, tbl[i].md);
      step(1);
      chk($sformatf("v%0d_clear_one_cycle", i), count_clear, 1'b0);
      step(7);
    end

    // Lap keeps the counter ticking
    press(LAP);
    chk("lap_state", state, 2'b11);
    wait_tick(n);
    chk("lap_tick_continues", n <= 10, 1'b1);
    step(8);

    // Clear from PAUSE zeroes the prescaler: full interval after restart
    press(SS);
    chk("pre_clear_pause", state, 2'b10);
    step(8);
    press(CLR);
    chk("clear_pulse", count_clear, 1'b1);
    chk("clear_idle", state, 2'b00);
    step(8);
    mode_sel = 1'b1;
    press(SS);
    chk("restart_run", state, 2'b01);
    wait_tick(n);
    chk("restart_full_interval", n, 10);
    chk("restart_mode", count_mode, 1'b1);

    // Reset mid-RUN, mid-debounce, mid-prescale
    set_btn(SS);
    step(2);
    reset = 1'b0;
    #1;
    chk("midrst_state", state, 2'b00);
    chk("midrst_enable", count_enable, 1'b0);
    chk("midrst_tick", count_tick, 1'b0);
    chk("midrst_clear", count_clear, 1'b0);
    chk("midrst_mode", count_mode, 1'b0);
    chk("midrst_lap_hold", lap_hold, 1'b0);
    set_btn(3'b000);
    mode_sel = 1'b0;
    step(1);
    reset = 1'b1;
    ev = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (state != 2'b00 || count_tick || count_clear || count_enable) ev++;
    end
    chk("post_reset_quiet", ev, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
